// File: rtl/counter_pkg.sv
// Shared counter-library types: widths, step size, down-counter state encoding.
// Latency: n/a (types only). Backpressure: n/a.
package counter_pkg;

  localparam int CNT_W    = 8;
  localparam int CNT_STEP = 2;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    LOADED  = 2'd1,
    RUN     = 2'd2,
    EXPIRED = 2'd3
  } dn_state_e;

endpackage

// File: rtl/even_step_dec.sv
// Combinational step decrement: next value, wrap flag and "next is zero" flag.
// Latency: zero (pure combinational). Backpressure: none.
module even_step_dec
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int STEP  = CNT_STEP
) (
  input  logic [WIDTH-1:0] i_q,
  output logic [WIDTH-1:0] o_next,
  output logic             o_wrap,
  output logic             o_zero_next
);

  localparam logic [WIDTH-1:0] STEP_V = WIDTH'(STEP);

  // q is always a multiple of STEP, so q < STEP means q == 0 and q == STEP lands on 0.
  assign o_next      = i_q - STEP_V;
  assign o_wrap      = (i_q < STEP_V);
  assign o_zero_next = (i_q == STEP_V);

endmodule

// File: rtl/even_down_counter.sv
// Even down-counter with load, terminal-count and borrow pulses; EVEN_DOWN_RELOAD_EN wraps to the last loaded value.
// Latency: one cycle from load/enable to q, tc, borrow. Backpressure: none, enable is accepted every cycle.
module even_down_counter
  import counter_pkg::*;
#(
  parameter int WIDTH = CNT_W,
  parameter int STEP  = CNT_STEP
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_enable,
  input  logic             i_load,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q,
  output logic             o_tc,
  output logic             o_borrow,
  output logic             o_zero
);

  localparam logic [WIDTH-1:0] STEP_V   = WIDTH'(STEP);
  localparam logic [WIDTH-1:0] LOAD_MSK = ~(STEP_V - WIDTH'(1));
  localparam logic [WIDTH-1:0] WRAP_V   = '0 - STEP_V;

  logic [WIDTH-1:0] r_q;
  logic             r_tc;
  logic             r_borrow;
  dn_state_e        r_state;
  dn_state_e        w_state_nxt;

  logic [WIDTH-1:0] w_next;
  logic             w_wrap;
  logic             w_zero_next;
  logic [WIDTH-1:0] w_load_val;
  logic [WIDTH-1:0] w_wrap_val;

  even_step_dec #(.WIDTH(WIDTH), .STEP(STEP)) u_dec (
    .i_q         (r_q),
    .o_next      (w_next),
    .o_wrap      (w_wrap),
    .o_zero_next (w_zero_next)
  );

  assign w_load_val = i_d & LOAD_MSK;

`ifdef EVEN_DOWN_RELOAD_EN
  logic [WIDTH-1:0] r_shadow;

  always_ff @(posedge i_clk) begin
    if (i_reset)     r_shadow <= '0;
    else if (i_load) r_shadow <= w_load_val;
  end

  assign w_wrap_val = (r_shadow != '0) ? r_shadow : WRAP_V;
`else
  assign w_wrap_val = WRAP_V;
`endif

  always_ff @(posedge i_clk) begin
    if (i_reset) r_state <= IDLE;
    else         r_state <= w_state_nxt;
  end

  // Every state reacts the same way to load/enable; only the target depends on landing on 0.
  always_comb begin
    w_state_nxt = r_state;
    if (i_load)          w_state_nxt = LOADED;
    else if (i_enable)   w_state_nxt = w_zero_next ? EXPIRED : RUN;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_q      <= '0;
      r_tc     <= 1'b0;
      r_borrow <= 1'b0;
    end else if (i_load) begin
      r_q      <= w_load_val;
      r_tc     <= 1'b0;
      r_borrow <= 1'b0;
    end else if (i_enable) begin
      r_q      <= w_wrap ? w_wrap_val : w_next;
      r_tc     <= (w_state_nxt == EXPIRED);
      r_borrow <= w_wrap;
    end else begin
      r_tc     <= 1'b0;
      r_borrow <= 1'b0;
    end
  end

  assign o_q      = r_q;
  assign o_tc     = r_tc;
  assign o_borrow = r_borrow;
  assign o_zero   = (r_q == '0);

endmodule

// File: doc/even_down_counter.md
Name: even_down_counter

Overview:
- Down-counting companion to the 8-bit even up-counter; counts down by 2 from a parallel-loaded value.
- Produces a one-cycle terminal-count pulse and a borrow flag on wrap.
- Serves as a countdown or timeout engine in the same counter library.
- Shares typedefs and the model class conventions in counter_pkg.

Parameters:
- WIDTH, 8, counter width in bits (even values only, >= 2).
- STEP, 2, decrement per enabled cycle (power of two, < 2**WIDTH).

Ports:
- clk  input  1  single clock; all state updates on posedge.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  count-down request for this cycle.
- load  input  1  parallel-load strobe.
- d  input  WIDTH  parallel load value.
- q  output  WIDTH  current count, registered.
- tc  output  1  terminal count, registered: one-cycle pulse when q becomes 0.
- borrow  output  1  registered: one-cycle pulse when a decrement wraps below 0.
- zero  output  1  combinational (q == 0).

Behaviour:
- Reset: q=0, tc=0, borrow=0, FSM=IDLE, reload shadow=0. Reset is synchronous: sampled on posedge clk only.
- Priority at each posedge: reset > load > enable > hold.
- Load: q <= {d[WIDTH-1:1],1'b0}. The LSB is forced to 0 so q is always even (general rule: low log2(STEP) bits cleared). Shadow <= the same value. FSM -> LOADED. tc=0 and borrow=0 that cycle.
- Enable, no load: q <= q - STEP modulo 2**WIDTH, one-cycle latency.
- tc=1 for exactly one cycle when the update makes q == 0 from a nonzero value. Also tc=1 when load of 0 is followed by no enable? No: tc is never asserted by load.
- Wrap: enable while q < STEP (i.e. q==0 for STEP=2) gives q <= 2**WIDTH - STEP (254 at WIDTH=8), borrow=1 for one cycle, tc=0.
- Enable=0 and load=0: q holds; tc and borrow deassert.
- load and enable in the same cycle: load wins, no decrement.
- FSM states:
  - IDLE: after reset.
  - LOADED: after load.
  - RUN: the first enabled decrement from LOADED or IDLE.
  - EXPIRED: entered on the tc cycle. Leaves to RUN on the next enable (which wraps), or to LOADED on load.
- FSM state is internal; it drives tc/borrow gating and is exported only via a debug hierarchy.
- Reset mid-count wins unconditionally: next cycle q=0, state IDLE, pending pulses dropped.
- No combinational path from inputs to q, tc, or borrow.

Optional Feature:
- Macro: EVEN_DOWN_RELOAD_EN.
- Defined: on the wrap condition, q <= shadow instead of 2**WIDTH-STEP, and borrow still pulses. If shadow == 0, it wraps as normal.
- Not defined: the shadow register is not built; wrap to 2**WIDTH-STEP.

Decomposition:
- counter_pkg additions:
  - localparam CNT_W=8 and CNT_STEP=2.
  - typedef logic [CNT_W-1:0] count_t.
  - typedef enum logic [1:0] {IDLE, LOADED, RUN, EXPIRED} dn_state_e.
  - Model class EightBitEvenDownCounter with constval/countval mirroring the up-counter model.
- One sub-module: even_step_dec. It is purely combinational: takes q and STEP, returns next value, wrap flag and zero-next flag. It is reused by the up/down variants.
- The FSM and registers stay in even_down_counter.

Test Plan:
- Reset held 10 cycles with enable=1 and d=8'hA0 -> q=0, tc=0, borrow=0 every cycle.
- load=1 with d=8'hA1 (161) -> next cycle q=160. load and enable together with d=8'h10 -> q=16, no decrement.
- load 160, then enable for 80 cycles -> q steps 158,156,...,0. tc=1 only on the cycle q reaches 0; zero=1 from then.
- From q=0, enable one cycle -> q=254 and borrow=1 for one cycle. With EVEN_DOWN_RELOAD_EN after a load of 160 -> q=160 and borrow=1.
- Count from 100, toggling enable every other cycle -> q only decrements on enabled cycles. Assert reset at q=60 -> q=0 the next cycle and state IDLE.
- 255 random cycles of load/enable/reset against the EightBitEvenDownCounter model -> q, tc and borrow match every cycle, and q is always even.
